// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } fetch_state_e;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam int          ENTRY_PC_W       = 32;
  localparam int          ENTRY_INSTR_W    = 32;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0]    pc;
    logic [ENTRY_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small pointer-based FIFO of fetched {pc, instr} entries with single-cycle flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  fetch_entry_t     push_data,
  output fetch_entry_t     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     slots [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;

  // Pointer and occupancy bookkeeping; a flush empties the queue in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else if (push && !flush) begin
      slots[wr_ptr] <= push_data;
    end
  end

  assign head  = slots[rd_ptr];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one read at a time and
// queues returned words for decode, with redirect/flush support.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              QUEUE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc_q;
  logic              issue;
  logic              push;
  logic              pop;
  logic              q_full;
  logic              q_empty;
  logic [CNT_W-1:0]  q_count;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  // A request goes out only when nothing is in flight and its queue slot is
  // guaranteed, so the response can always be pushed. Reset gates it directly.
  assign issue = !rst && (state == S_ISSUE) && !redirect_valid &&
                 (q_count < CNT_W'(QUEUE_DEPTH));

  assign push = (state == S_WAIT) && mem_rvalid && !redirect_valid && !q_full;
  assign pop  = out_valid && out_ready && !redirect_valid;

  assign push_entry = {pc_q, mem_rdata};

  // PC and fetch state; a redirect overrides everything and decides whether an
  // in-flight response must still be swallowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_ISSUE;
      pc_q  <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc & ~ADDR_W'(INSTR_BYTES - 1);
      case (state)
        S_WAIT:  state <= mem_rvalid ? S_ISSUE : S_DROP;
        S_DROP:  state <= mem_rvalid ? S_ISSUE : S_DROP;
        default: state <= S_ISSUE;
      endcase
    end else begin
      case (state)
        S_ISSUE: if (issue) state <= S_WAIT;
        S_WAIT: begin
          if (mem_rvalid) begin
            state <= S_ISSUE;
            pc_q  <= pc_q + ADDR_W'(INSTR_BYTES);
          end
        end
        S_DROP:  if (mem_rvalid) state <= S_ISSUE;
        default: state <= S_ISSUE;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_data (push_entry),
    .head      (head_entry),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign mem_req   = issue;
  assign mem_addr  = pc_q;
  assign out_valid = !q_empty;
  assign out_pc    = head_entry.pc;
  assign out_instr = head_entry.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based reference model is compared
// against the DUT every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata  = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid = 1'b0;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W (32), .DATA_W (32), .RESET_PC (BASE), .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk (clk), .rst (rst),
    .mem_req (mem_req), .mem_addr (mem_addr),
    .mem_rvalid (mem_rvalid), .mem_rdata (mem_rdata),
    .redirect_valid (redirect_valid), .redirect_pc (redirect_pc),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_instr (out_instr), .out_pc (out_pc)
  );

  // Second instance whose reset PC sits at the top of the address space.
  fetch_unit #(
    .ADDR_W (32), .DATA_W (32), .RESET_PC (32'hFFFF_FFFC), .QUEUE_DEPTH (DEPTH)
  ) dut_wrap (
    .clk (clk), .rst (rst),
    .mem_req (w_req), .mem_addr (w_addr),
    .mem_rvalid (w_rvalid), .mem_rdata (32'h0000_0013),
    .redirect_valid (1'b0), .redirect_pc (32'h0),
    .out_valid (w_valid), .out_ready (1'b1),
    .out_instr (w_instr), .out_pc (w_pc)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h0050_0093;
      32'h8000_0004: return 32'h00a0_0113;
      32'h8000_0008: return 32'h0020_81b3;
      32'h8000_0010: return 32'h4002_2283;
      default:       return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  // Reference model: program order as a plain queue of {pc, instr}, plus two
  // flags for "a wanted response is in flight" and "the next response is stale".
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  bit          m_busy;
  bit          m_drop;

  function automatic void model_reset();
    m_q.delete();
    m_pc   = BASE;
    m_busy = 1'b0;
    m_drop = 1'b0;
  endfunction

  always @(posedge clk) begin
    bit can_issue;
    bit do_pop;
    if (!rst) begin
      if (redirect_valid) begin
        m_q.delete();
        if (m_busy) begin
          m_busy = 1'b0;
          m_drop = !mem_rvalid;
        end else if (m_drop && mem_rvalid) begin
          m_drop = 1'b0;
        end
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        can_issue = !m_busy && !m_drop && (m_q.size() < DEPTH);
        do_pop    = (m_q.size() > 0) && out_ready;
        if (do_pop) void'(m_q.pop_front());
        if (m_busy && mem_rvalid) begin
          m_q.push_back({m_pc, mem_rdata});
          m_pc   = m_pc + 32'd4;
          m_busy = 1'b0;
        end else if (m_drop && mem_rvalid) begin
          m_drop = 1'b0;
        end else if (can_issue) begin
          m_busy = 1'b1;
        end
      end
    end
  end

  // Memory responder: one response per request after lat cycles. Pending
  // responses survive a reset so late data reaches the DUT afterwards.
  int          lat      = 1;
  bit          rand_lat = 1'b0;
  int          mem_cd   = 0;
  logic [31:0] mem_pend_addr = 32'h0;

  always @(negedge clk) begin
    if (mem_cd > 0) begin
      mem_cd--;
      if (mem_cd == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(mem_pend_addr);
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hDEAD_BEEF;
      end
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    if (mem_req === 1'b1) begin
      mem_cd        = rand_lat ? int'($urandom_range(1, 4)) : lat;
      mem_pend_addr = mem_addr;
    end
  end

  // Latency-1 responder for the wrap instance, logging its first two addresses.
  logic [31:0] w_addrs[$];
  bit          w_pend = 1'b0;

  always @(negedge clk) begin
    w_rvalid = w_pend;
    w_pend   = 1'b0;
    #1;
    if (w_req === 1'b1) begin
      w_pend = 1'b1;
      if (w_addrs.size() < 2) w_addrs.push_back(w_addr);
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  int          req_count = 0;
  logic [63:0] pop_log[$];

  always @(negedge clk) begin
    bit exp_req;
    #1;
    if (rst) begin
      check("req_in_reset", {63'd0, mem_req}, 64'd0);
      check("addr_in_reset", {32'd0, mem_addr}, {32'd0, BASE});
      check("valid_in_reset", {63'd0, out_valid}, 64'd0);
    end else begin
      exp_req = !m_busy && !m_drop && (m_q.size() < DEPTH) && !redirect_valid;
      check("mem_req", {63'd0, mem_req}, {63'd0, exp_req});
      if (exp_req) check("mem_addr", {32'd0, mem_addr}, {32'd0, m_pc});
      check("out_valid", {63'd0, out_valid}, {63'd0, (m_q.size() > 0)});
      if (m_q.size() > 0) check("out_head", {out_pc, out_instr}, m_q[0]);
      if (mem_req === 1'b1) req_count++;
      if (out_valid && out_ready && !redirect_valid) pop_log.push_back({out_pc, out_instr});
    end
  end

  // Async reset asserted mid-cycle, released on a falling edge.
  task automatic do_reset();
    next_cycle();
    #3;
    rst = 1'b1;
    model_reset();
    repeat (2) next_cycle();
    rst = 1'b0;
  endtask

  task automatic wait_for_req(input string name, input logic [31:0] addr, input bit any_addr,
                              input bit need_valid);
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      next_cycle();
      #2;
      if (mem_req && (any_addr || mem_addr == addr) && (!need_valid || out_valid)) found = 1'b1;
    end
    check(name, {63'd0, found}, 64'd1);
  endtask

  task automatic applyStimulus();
    logic [63:0] seq_exp [3];
    logic [63:0] e;
    bit          found;

    // Reset values, then the first request right after release.
    rst = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    repeat (3) next_cycle();
    #2;
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst_mem_addr", {32'd0, mem_addr}, {32'd0, BASE});
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_instr", {32'd0, out_instr}, 64'd0);
    check("rst_out_pc", {32'd0, out_pc}, 64'd0);
    next_cycle();
    rst = 1'b0;
    #2;
    check("first_req", {63'd0, mem_req}, 64'd1);
    check("first_addr", {32'd0, mem_addr}, {32'd0, BASE});

    // Sequential fetch at latency 1.
    repeat (12) next_cycle();
    seq_exp[0] = {32'h8000_0000, 32'h0050_0093};
    seq_exp[1] = {32'h8000_0004, 32'h00a0_0113};
    seq_exp[2] = {32'h8000_0008, 32'h0020_81b3};
    for (int i = 0; i < 3; i++) begin
      e = (i < pop_log.size()) ? pop_log[i] : 64'd0;
      check($sformatf("seq_%0d", i), e, seq_exp[i]);
    end
    check("wrap_first", {32'd0, (w_addrs.size() > 0) ? w_addrs[0] : 32'h1}, {32'd0, 32'hFFFF_FFFC});
    check("wrap_second", {32'd0, (w_addrs.size() > 1) ? w_addrs[1] : 32'h1}, 64'd0);

    // Backpressure: two fetches fill the queue, then requests stop.
    out_ready = 1'b0;
    do_reset();
    req_count = 0;
    repeat (13) next_cycle();
    #2;
    check("bp_req_count", 64'(req_count), 64'd2);
    check("bp_head", {out_pc, out_instr}, {32'h8000_0000, 32'h0050_0093});
    next_cycle();
    out_ready = 1'b1;
    pop_log.delete();
    repeat (24) next_cycle();
    for (int i = 0; i < 6; i++) begin
      e = (i < pop_log.size()) ? pop_log[i] : 64'd0;
      check($sformatf("bp_order_%0d", i), e,
            {BASE + 32'(4 * i), mem_word(BASE + 32'(4 * i))});
    end

    // Redirect while waiting on the 8000_0004 response.
    out_ready = 1'b0;
    lat = 3;
    do_reset();
    wait_for_req("redir_find_req", BASE + 32'd4, 1'b0, 1'b0);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = BASE + 32'h10;
    next_cycle();
    redirect_valid = 1'b0;
    #2;
    check("redir_flushed", {63'd0, out_valid}, 64'd0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      next_cycle();
      #2;
      if (out_valid) found = 1'b1;
    end
    check("redir_head_seen", {63'd0, found}, 64'd1);
    check("redir_head", {out_pc, out_instr}, {32'h8000_0010, 32'h4002_2283});

    // Redirect in the same cycle as the response, to a misaligned target.
    out_ready = 1'b1;
    lat = 2;
    wait_for_req("coinc_find_req", 32'h0, 1'b1, 1'b0);
    next_cycle();
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0016;
    next_cycle();
    redirect_valid = 1'b0;
    #2;
    check("coinc_req", {63'd0, mem_req}, 64'd1);
    check("coinc_addr", {32'd0, mem_addr}, {32'd0, 32'h8000_0014});
    check("coinc_no_push", {63'd0, out_valid}, 64'd0);

    // Async reset between edges while a fetch is outstanding.
    out_ready = 1'b0;
    lat = 3;
    wait_for_req("arst_find_req", 32'h0, 1'b1, 1'b1);
    next_cycle();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_req", {63'd0, mem_req}, 64'd0);
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #2;
    check("arst_refetch_req", {63'd0, mem_req}, 64'd1);
    check("arst_refetch_addr", {32'd0, mem_addr}, {32'd0, BASE});

    // Randomised traffic against the model.
    rand_lat = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      next_cycle();
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        redirect_valid = 1'b1;
        if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        else                           redirect_pc = BASE + $urandom_range(0, 255);
      end else begin
        redirect_valid = 1'b0;
      end
    end
    next_cycle();
    redirect_valid = 1'b0;
    repeat (10) next_cycle();
  endtask

  task automatic checkOutput();
    $display("[TB] Result: errors=%0d of %0d checks", n_errors, n_checks);
  endtask

  initial begin
    applyStimulus();
    checkOutput();
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
